// File: rtl/com_uart_responder.sv
// COM-port register block bridging the CPU bus to an 8N1 UART,
// with TX/RX FIFOs, a runtime baud divisor and a level interrupt.
module com_uart_responder #(
    parameter logic [7:0]  BASE_ADDR   = 8'h10,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] com_addr,
    input  logic       com_wr_en,
    input  logic [7:0] com_wr,
    input  logic       com_rd_en,
    output logic [7:0] com_rd,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic [7:0] off;
    logic       hit;
    logic       wr_data, wr_divlo, wr_divhi;
    logic       rd_data, rd_stat;

    // offset arithmetic keeps decode correct for any BASE_ADDR
    assign off      = com_addr - BASE_ADDR;
    assign hit      = (off[7:2] == 6'd0);
    assign wr_data  = com_wr_en & hit & (off[1:0] == 2'd0);
    assign wr_divlo = com_wr_en & hit & (off[1:0] == 2'd2);
    assign wr_divhi = com_wr_en & hit & (off[1:0] == 2'd3);
    assign rd_data  = com_rd_en & hit & (off[1:0] == 2'd0);
    assign rd_stat  = com_rd_en & hit & (off[1:0] == 2'd1);

    logic [15:0] div_q, div_d, div_eff;

    always_comb begin
        div_d = div_q;
        if (wr_divlo) div_d[7:0]  = com_wr;
        if (wr_divhi) div_d[15:8] = com_wr;
    end

    assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_push, tx_pop, tx_empty, tx_full, tx_idle;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL);
    assign tx_push  = wr_data & (~tx_full | tx_pop);

    always_comb begin
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    logic [1:0]  tx_st_q, tx_st_d;
    logic [15:0] tx_tick_q, tx_tick_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_last;

    assign tx_last = (tx_tick_q == tx_div_q - 16'd1);
    assign tx_idle = tx_empty & (tx_st_q == TX_IDLE);

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tick_d = tx_tick_q + 16'd1;
        tx_div_d  = tx_div_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_line_d = tx_line_q;
        tx_pop    = 1'b0;
        unique case (tx_st_q)
            TX_IDLE: begin
                tx_tick_d = '0;
                tx_line_d = 1'b1;
                if (!tx_empty) tx_pop = 1'b1;
            end
            TX_START: begin
                if (tx_last) begin
                    tx_tick_d = '0;
                    tx_st_d   = TX_DATA;
                    tx_bit_d  = '0;
                    tx_line_d = tx_sh_q[0];
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_tick_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d   = TX_STOP;
                        tx_line_d = 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                        tx_line_d = tx_sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    tx_tick_d = '0;
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                    end else begin
                        tx_st_d   = TX_IDLE;
                        tx_line_d = 1'b1;
                    end
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        // every frame start latches its own divisor
        if (tx_pop) begin
            tx_st_d   = TX_START;
            tx_sh_d   = tx_mem_q[tx_rp_q];
            tx_div_d  = div_eff;
            tx_tick_d = '0;
            tx_line_d = 1'b0;
        end
    end

    logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    logic [2:0]  rx_st_q, rx_st_d;
    logic [15:0] rx_tick_q, rx_tick_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_done, rx_ferr;

    assign rx_fall = rx_s3_q & ~rx_s2_q;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_tick_d = rx_tick_q + 16'd1;
        rx_div_d  = rx_div_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_done   = 1'b0;
        rx_ferr   = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (rx_fall) begin
                    rx_st_d  = RX_START;
                    rx_div_d = div_eff;
                end
            end
            RX_START: begin
                if (rx_tick_q == (rx_div_q >> 1) - 16'd1) begin
                    rx_tick_d = '0;
                    rx_bit_d  = '0;
                    rx_st_d   = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick_q == rx_div_q - 16'd1) begin
                    rx_tick_d = '0;
                    rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d  = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick_q == rx_div_q - 16'd1) begin
                    rx_tick_d = '0;
                    rx_done   = rx_s2_q;
                    rx_ferr   = ~rx_s2_q;
                    rx_st_d   = rx_s2_q ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: begin
                rx_tick_d = '0;
                if (rx_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_push, rx_pop, rx_empty, rx_full, rx_ovf;
    logic          ov_q, ov_d, fe_q, fe_d;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL);
    assign rx_pop   = rd_data & ~rx_empty;
    assign rx_push  = rx_done & (~rx_full | rx_pop);
    assign rx_ovf   = rx_done & rx_full & ~rx_pop;

    always_comb begin
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        ov_d     = rx_ovf  | (ov_q & ~rd_stat);
        fe_d     = rx_ferr | (fe_q & ~rd_stat);
    end

    always_comb begin
        com_rd = 8'h00;
        if (com_rd_en & hit) begin
            unique case (off[1:0])
                2'd0: com_rd = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
                2'd1: com_rd = {3'b0, fe_q, ov_q, tx_idle, tx_full, ~rx_empty};
                2'd2: com_rd = div_q[7:0];
                2'd3: com_rd = div_q[15:8];
                default: com_rd = 8'h00;
            endcase
        end
    end

    assign uart_tx = tx_line_q;
    assign irq     = ~rx_empty | ov_q | fe_q;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= com_wr;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= DEFAULT_DIV;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            tx_st_q   <= TX_IDLE;
            tx_tick_q <= '0;
            tx_div_q  <= 16'd2;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_line_q <= 1'b1;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_tick_q <= '0;
            rx_div_q  <= 16'd2;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            ov_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_st_q   <= tx_st_d;
            tx_tick_q <= tx_tick_d;
            tx_div_q  <= tx_div_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_line_q <= tx_line_d;
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_tick_q <= rx_tick_d;
            rx_div_q  <= rx_div_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            ov_q      <= ov_d;
            fe_q      <= fe_d;
        end
    end

endmodule
